// File: rtl/qft4_pkg.sv
// Shared state type, twiddle exponent helper and width helpers for the sequenced 4-point QFT.
// Latency: none (types and constant functions only).
// Backpressure: none.
package qft4_pkg;

    typedef enum logic [1:0] {LOAD, CALC, OUT} qft4_state_t;

    localparam int N_PTS = 4;

    function automatic int acc_width(input int in_w);
        return in_w + 2;
    endfunction

    function automatic int out_width(input int in_w, input int frac_w);
        return in_w + frac_w + 1;
    endfunction

    // The 2-bit product wraps, which is exactly (j*k) mod 4.
    function automatic logic [1:0] twiddle_exp(input logic [1:0] j, input logic [1:0] k,
                                               input logic inv);
        logic [1:0] p;
        p = j * k;
        return inv ? -p : p;
    endfunction

endpackage

// File: rtl/qft4_rot_acc.sv
// Rotates one complex sample by i^e and adds it to the running accumulator.
// Latency: combinational.
// Backpressure: none; the controller decides when the sum is captured.
module qft4_rot_acc #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 10
) (
    input  logic signed [ACC_W-1:0] acc_re,
    input  logic signed [ACC_W-1:0] acc_im,
    input  logic signed [IN_W-1:0]  x_re,
    input  logic signed [IN_W-1:0]  x_im,
    input  logic        [1:0]       e,
    output logic signed [ACC_W-1:0] sum_re,
    output logic signed [ACC_W-1:0] sum_im
);

    logic signed [ACC_W-1:0] xr;
    logic signed [ACC_W-1:0] xi;
    logic signed [ACC_W-1:0] t_re;
    logic signed [ACC_W-1:0] t_im;

    // Widen before negating so the most negative input flips sign without wrapping.
    assign xr = {{(ACC_W-IN_W){x_re[IN_W-1]}}, x_re};
    assign xi = {{(ACC_W-IN_W){x_im[IN_W-1]}}, x_im};

    always_comb begin
        t_re = xr;
        t_im = xi;
        case (e)
            2'd0: begin t_re = xr;  t_im = xi;  end
            2'd1: begin t_re = -xi; t_im = xr;  end
            2'd2: begin t_re = -xr; t_im = -xi; end
            default: begin t_re = xi; t_im = -xr; end
        endcase
    end

    assign sum_re = acc_re + t_re;
    assign sum_im = acc_im + t_im;

endmodule

// File: rtl/qft4_seq_ctrl.sv
// Sequenced 4-point QFT: loads 4 complex samples, then builds each row X[k] one term per cycle (QFT4_INVERSE_EN adds conjugate twiddles).
// Latency: first row valid 4 cycles after the 4th accept, each later row 4 cycles after the previous handshake.
// Backpressure: row held while out_valid && !out_ready; in_ready low from 4th accept until the k=3 handshake.
module qft4_seq_ctrl
    import qft4_pkg::*;
#(
    parameter  int IN_W   = 8,
    parameter  int FRAC_W = 4,
    localparam int OUT_W  = out_width(IN_W, FRAC_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_re,
    input  logic signed [IN_W-1:0]  in_im,
`ifdef QFT4_INVERSE_EN
    input  logic                    inverse,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_re,
    output logic signed [OUT_W-1:0] out_im,
    output logic        [1:0]       out_idx,
    output logic                    out_last
);

    localparam int ACC_W = acc_width(IN_W);

    qft4_state_t state;
    qft4_state_t state_nxt;

    logic signed [IN_W-1:0]  smp_re [N_PTS];
    logic signed [IN_W-1:0]  smp_im [N_PTS];
    logic        [1:0]       wr_idx;
    logic        [1:0]       j;
    logic        [1:0]       k;
    logic signed [ACC_W-1:0] acc_re;
    logic signed [ACC_W-1:0] acc_im;
    logic signed [ACC_W-1:0] sum_re;
    logic signed [ACC_W-1:0] sum_im;
    logic signed [OUT_W-1:0] sum_re_ext;
    logic signed [OUT_W-1:0] sum_im_ext;
    logic        [1:0]       e;
    logic                    accept;
    logic                    hs;
    logic                    inv_cur;

`ifdef QFT4_INVERSE_EN
    logic inv_q;

    // Direction is latched with the last sample so mid-frame toggles are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         inv_q <= 1'b0;
        else if (accept && wr_idx == 2'd3)  inv_q <= inverse;
    end
    assign inv_cur = inv_q;
`else
    assign inv_cur = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (accept && wr_idx == 2'd3) state_nxt = CALC;
            CALC:    if (j == 2'd3)                state_nxt = OUT;
            OUT:     if (out_ready)                state_nxt = (k == 2'd3) ? LOAD : CALC;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        accept   = 1'b0;
        hs       = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            OUT:     hs = out_ready;
            default: ;
        endcase
    end

    assign e = twiddle_exp(j, k, inv_cur);

    qft4_rot_acc #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_rot_acc (
        .acc_re (acc_re),
        .acc_im (acc_im),
        .x_re   (smp_re[j]),
        .x_im   (smp_im[j]),
        .e      (e),
        .sum_re (sum_re),
        .sum_im (sum_im)
    );

    assign sum_re_ext = {{(OUT_W-ACC_W){sum_re[ACC_W-1]}}, sum_re};
    assign sum_im_ext = {{(OUT_W-ACC_W){sum_im[ACC_W-1]}}, sum_im};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PTS; i++) begin
                smp_re[i] <= '0;
                smp_im[i] <= '0;
            end
            wr_idx    <= '0;
            j         <= '0;
            k         <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                smp_re[wr_idx] <= in_re;
                smp_im[wr_idx] <= in_im;
                wr_idx         <= wr_idx + 2'd1;
                if (wr_idx == 2'd3) begin
                    j      <= '0;
                    k      <= '0;
                    acc_re <= '0;
                    acc_im <= '0;
                end
            end
            if (state == CALC) begin
                acc_re <= sum_re;
                acc_im <= sum_im;
                j      <= j + 2'd1;
                // The 1/2 normalisation folds into the fractional shift.
                if (j == 2'd3) begin
                    out_re    <= sum_re_ext <<< (FRAC_W-1);
                    out_im    <= sum_im_ext <<< (FRAC_W-1);
                    out_idx   <= k;
                    out_last  <= (k == 2'd3);
                    out_valid <= 1'b1;
                end
            end
            if (hs) begin
                out_valid <= 1'b0;
                j         <= '0;
                acc_re    <= '0;
                acc_im    <= '0;
                if (k == 2'd3) wr_idx <= '0;
                else           k      <= k + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_qft4_seq_ctrl.sv
// Bench for qft4_seq_ctrl: directed vector table, stall/reset corner cases, random frames against a DFT model.
// Latency: checks the 4-cycle row latency and the 24-cycle unstalled frame period.
// Backpressure: holds out_ready low for 3 cycles and pulses in_valid while the block is busy.
module tb_qft4_seq_ctrl;

    localparam int IN_W   = 8;
    localparam int FRAC_W = 4;
    localparam int OUT_W  = 13;
    localparam int NONE   = 4;

    typedef logic signed [15:0] s16_t;
    typedef struct packed {
        s16_t [3:0] xr;
        s16_t [3:0] xi;
        s16_t [3:0] er;
        s16_t [3:0] ei;
        logic       inv;
        logic [2:0] stall_k;
        logic [2:0] rst_k;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_re;
    logic signed [IN_W-1:0]  in_im;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_re;
    logic signed [OUT_W-1:0] out_im;
    logic        [1:0]       out_idx;
    logic                    out_last;
`ifdef QFT4_INVERSE_EN
    logic                    inverse;
`endif

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_acc = 0;
    bit cur_inv  = 1'b0;

    qft4_seq_ctrl #(.IN_W(IN_W), .FRAC_W(FRAC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
`ifdef QFT4_INVERSE_EN
        .inverse   (inverse),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Direct DFT: X[k] = sum_j x[j] * i^(jk), scaled by 2^FRAC_W / 2.
    task automatic dft_model(input int xr[4], input int xi[4], input bit inv,
                             output int er[4], output int ei[4]);
        for (int kk = 0; kk < 4; kk++) begin
            int sr, si;
            sr = 0;
            si = 0;
            for (int jj = 0; jj < 4; jj++) begin
                int n, cr, ci;
                n  = (jj * kk) % 4;
                if (inv) n = (4 - n) % 4;
                cr = (n == 0) ? 1 : (n == 2) ? -1 : 0;
                ci = (n == 1) ? 1 : (n == 3) ? -1 : 0;
                sr += xr[jj] * cr - xi[jj] * ci;
                si += xr[jj] * ci + xi[jj] * cr;
            end
            er[kk] = sr * (1 << (FRAC_W - 1));
            ei[kk] = si * (1 << (FRAC_W - 1));
        end
    endtask

    function automatic vec_t mk(input int x0r, input int x0i, input int x1r, input int x1i,
                                input int x2r, input int x2i, input int x3r, input int x3i,
                                input int e0r, input int e0i, input int e1r, input int e1i,
                                input int e2r, input int e2i, input int e3r, input int e3i,
                                input int inv, input int stall_k, input int rst_k);
        vec_t v;
        v.xr      = {16'(x3r), 16'(x2r), 16'(x1r), 16'(x0r)};
        v.xi      = {16'(x3i), 16'(x2i), 16'(x1i), 16'(x0i)};
        v.er      = {16'(e3r), 16'(e2r), 16'(e1r), 16'(e0r)};
        v.ei      = {16'(e3i), 16'(e2i), 16'(e1i), 16'(e0i)};
        v.inv     = 1'(inv);
        v.stall_k = 3'(stall_k);
        v.rst_k   = 3'(rst_k);
        return v;
    endfunction

    // Called and returns at a falling edge.
    task automatic run_frame(input int xr[4], input int xi[4], input int er[4], input int ei[4],
                             input int stall_k, input int rst_k, input bit chk_b2b);
        int t_ref, waited;
        for (int jj = 0; jj < 4; jj++) begin
            chk("in_ready_load", int'(in_ready), 1);
            in_valid = 1'b1;
            in_re    = IN_W'(xr[jj]);
            in_im    = IN_W'(xi[jj]);
`ifdef QFT4_INVERSE_EN
            inverse  = (jj == 3) ? cur_inv : ~cur_inv;
`endif
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
`ifdef QFT4_INVERSE_EN
        inverse  = ~cur_inv;
`endif
        if (chk_b2b) chk("frame_period", cyc - last_acc, 24);
        last_acc = cyc;
        t_ref    = cyc;
        for (int kk = 0; kk < 4; kk++) begin
            waited = 0;
            while (!out_valid && waited < 12) begin
                if (kk == rst_k && waited == 2) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk("rst_out_valid", int'(out_valid), 0);
                    chk("rst_in_ready",  int'(in_ready),  1);
                    chk("rst_out_re",    int'(out_re),    0);
                    chk("rst_out_im",    int'(out_im),    0);
                    chk("rst_out_idx",   int'(out_idx),   0);
                    chk("rst_out_last",  int'(out_last),  0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                @(negedge clk);
                waited++;
            end
            if (!out_valid) begin
                chk("row_timeout", 0, 1);
                return;
            end
            chk("row_latency", cyc - t_ref, 4);
            chk("in_ready_busy", int'(in_ready), 0);
            chk("out_idx", int'(out_idx), kk);
            chk("out_last", int'(out_last), int'(kk == 3));
            chk("out_re", int'(out_re), er[kk]);
            chk("out_im", int'(out_im), ei[kk]);
            if (kk == stall_k) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    in_valid = 1'b1;
                    in_re    = IN_W'($urandom);
                    in_im    = IN_W'($urandom);
                    @(negedge clk);
                    chk("hold_valid",    int'(out_valid), 1);
                    chk("hold_re",       int'(out_re),    er[kk]);
                    chk("hold_im",       int'(out_im),    ei[kk]);
                    chk("hold_idx",      int'(out_idx),   kk);
                    chk("hold_in_ready", int'(in_ready),  0);
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            t_ref = cyc;
        end
        chk("done_out_valid", int'(out_valid), 0);
        chk("done_in_ready",  int'(in_ready),  1);
    endtask

    initial begin
        vec_t tbl[$];
        int   xr[4], xi[4], er[4], ei[4];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
`ifdef QFT4_INVERSE_EN
        inverse   = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("reset_in_ready",  int'(in_ready),  1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_re",    int'(out_re),    0);
        chk("reset_out_im",    int'(out_im),    0);
        chk("reset_out_idx",   int'(out_idx),   0);
        chk("reset_out_last",  int'(out_last),  0);
        rst_n = 1'b1;
        @(negedge clk);

        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   8, 0, 8, 0, 8, 0, 8, 0,   0, NONE, NONE));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,   8, 0, 0, 8, -8, 0, 0, -8,   0, NONE, NONE));
        tbl.push_back(mk(-128, -128, -128, -128, -128, -128, -128, -128,
                         -4096, -4096, 0, 0, 0, 0, 0, 0,   0, NONE, NONE));
        tbl.push_back(mk(0, 0, -128, 0, 0, 0, 0, 0,
                         -1024, 0, 0, -1024, 1024, 0, 0, 1024,   0, NONE, NONE));
        tbl.push_back(mk(1, 2, 3, -4, 0, 0, 0, 0,   32, -16, 40, 40, -16, 48, -24, -8,   0, NONE, NONE));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   8, 0, 8, 0, 8, 0, 8, 0,   0, 1, NONE));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   8, 0, 8, 0, 8, 0, 8, 0,   0, NONE, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   8, 0, 8, 0, 8, 0, 8, 0,   0, NONE, NONE));
`ifdef QFT4_INVERSE_EN
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,   8, 0, 0, -8, -8, 0, 0, 8,   1, NONE, NONE));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,   8, 0, 0, 8, -8, 0, 0, -8,   0, NONE, NONE));
`endif

        for (int t = 0; t < tbl.size(); t++) begin
            for (int jj = 0; jj < 4; jj++) begin
                xr[jj] = int'($signed(tbl[t].xr[jj]));
                xi[jj] = int'($signed(tbl[t].xi[jj]));
                er[jj] = int'($signed(tbl[t].er[jj]));
                ei[jj] = int'($signed(tbl[t].ei[jj]));
            end
            cur_inv = tbl[t].inv;
            run_frame(xr, xi, er, ei, int'(tbl[t].stall_k), int'(tbl[t].rst_k), 1'b0);
        end

        for (int f = 0; f < 16; f++) begin
            for (int jj = 0; jj < 4; jj++) begin
                xr[jj] = int'($urandom_range(255)) - 128;
                xi[jj] = int'($urandom_range(255)) - 128;
            end
`ifdef QFT4_INVERSE_EN
            cur_inv = 1'($urandom_range(1));
`else
            cur_inv = 1'b0;
`endif
            dft_model(xr, xi, cur_inv, er, ei);
            run_frame(xr, xi, er, ei, NONE, NONE, f > 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/qft4_seq_ctrl.md
Name: qft4_seq_ctrl

Overview:
- Sequenced 4-point QFT engine. It replaces the all-combinational 4-row evaluation with one shared complex accumulate lane.
- Accepts a frame of 4 complex samples over a valid/ready stream and computes output rows k=0..3 one term per cycle, using twiddle W = i^((j*k) mod 4) and 1/2 normalisation.
- Streams each row out with valid/ready backpressure.
- Sits between the sample-capture logic and the downstream result consumer.

Parameters:
- IN_W, 8, signed integer width of each input real/imag component.
- FRAC_W, 4, fractional bits of outputs. OUT_W = IN_W+FRAC_W+1 (13 at defaults).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_re  in  IN_W  signed real part of sample x[j].
- in_im  in  IN_W  signed imag part of sample x[j].
- out_valid  out  1  output row valid.
- out_ready  in  1  consumer accepts row.
- out_re  out  OUT_W  signed real part of X[k], FRAC_W fractional bits.
- out_im  out  OUT_W  signed imag part of X[k].
- out_idx  out  2  row index k of the current output.
- out_last  out  1  high with row k=3.
- inverse  in  1  present only with QFT4_INVERSE_EN.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: state=LOAD; all outputs 0 except in_ready=1; sample buffer, accumulator, j and k cleared to 0.
- States: LOAD, CALC, OUT.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready writes buf[wr_idx] and increments wr_idx.
  - The 4th accept moves to CALC with k=0, j=0, acc=0.
- CALC:
  - in_ready=0.
  - Each cycle: acc += rot(buf[j], e), with e=(j*k)&3, then j++.
  - After the j=3 cycle, the registers load out_re/out_im = acc <<< (FRAC_W-1), out_idx=k, out_last=(k==3), out_valid=1. State moves to OUT.
- rot(x,e) for e=0,1,2,3: (re,im), (-im,re), (-re,-im), (im,-re).
- Operand width:
  - Operands are sign-extended to IN_W+2 before negation, so -128 negates to +128 without wrap.
  - The accumulator is IN_W+2 bits; the sum of 4 terms cannot overflow.
- OUT:
  - Outputs are held stable while out_valid && !out_ready.
  - On handshake: if k==3, clear out_valid, go to LOAD, wr_idx=0. Otherwise k++, j=0, acc=0, clear out_valid, go to CALC.
- Latency:
  - First out_valid is asserted 4 cycles after the edge that accepts sample 3.
  - Each subsequent row follows 4 cycles after the previous handshake.
  - Unstalled frame: 4 load cycles + 4x(4 CALC + 1 OUT) = 24 cycles.
- No overlap: in_ready=0 from the 4th accept until the k=3 handshake completes.
- Reset mid-operation: immediate return to the reset state. The partial frame is discarded, with no out_valid glitch.
- in_valid while in_ready=0 is ignored. The data need not be held by the source.

Optional Feature:
- Macro: QFT4_INVERSE_EN.
- Defined:
  - The inverse port exists.
  - It is sampled on the 4th LOAD accept and held for the frame.
  - When it is 1, e=(-(j*k))&3 (conjugate twiddles, inverse QFT).
- Undefined: no port; forward transform only.

Decomposition:
- Package qft4_pkg holds:
  - state enum {LOAD, CALC, OUT};
  - constant N_PTS=4;
  - function twiddle_exp(j,k,inv) returning the 2-bit exponent;
  - width helpers for ACC_W and OUT_W.
- One sub-module, qft4_rot_acc: combinational rot-and-add of one complex term into the accumulator. The controller holds all state.

Test Plan:
- Impulse x=[(1,0),(0,0),(0,0),(0,0)] -> 4 rows, each out_re=8 (0.5), out_im=0, out_idx 0..3, out_last only on k=3; first out_valid exactly 4 cycles after the 4th accept.
- x=[(0,0),(1,0),(0,0),(0,0)] -> k0 (8,0), k1 (0,8), k2 (-8,0), k3 (0,-8).
- All samples (-128,-128) -> k0 (-4096,-4096); k1..k3 (0,0). Separately, x1=(-128,0), others 0 -> k1 (0,-1024), k3 (0,1024); checks negation of -128.
- Backpressure: out_ready low 3 cycles at k=1 -> out_valid, out_re, out_im and out_idx held; in_ready=0; in_valid pulses are ignored; the frame then completes correctly. Back-to-back frames with out_ready=1 take 24 cycles each.
- rst_n pulsed low mid-CALC of k=2 -> outputs 0 and in_ready=1 asynchronously; the next impulse frame produces the correct results.
- With QFT4_INVERSE_EN, inverse=1 and x1=(1,0) -> k1 (0,-8), k3 (0,8). inverse toggled mid-frame has no effect until the next frame.
